// File: rtl/adc_code_averager.sv
// Windowed averager for flash-ADC codes: it accumulates 2^LOG2_N strobed samples and
// presents the rounded mean plus the window min/max over a valid/ready handshake.
module adc_code_averager #(
   parameter int CODE_W = 8,
   parameter int LOG2_N = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              sample_en,
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] avg_data,
   output logic [CODE_W-1:0] min_code,
   output logic [CODE_W-1:0] max_code,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              overrun,
   input  logic              clr_overrun
);

   localparam int ACC_W = CODE_W + LOG2_N;
   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t              state_reg;
   logic [ACC_W-1:0]    acc_reg;
   logic [LOG2_N-1:0]   cnt_reg;
   logic [CODE_W-1:0]   min_reg;
   logic [CODE_W-1:0]   max_reg;
   logic [CODE_W-1:0]   avg_data_reg;
   logic [CODE_W-1:0]   min_code_reg;
   logic [CODE_W-1:0]   max_code_reg;
   logic                avg_valid_reg;
   logic                overrun_reg;

   logic [ACC_W-1:0]    acc_next;
   logic [CODE_W-1:0]   min_next;
   logic [CODE_W-1:0]   max_next;
   logic [ACC_W:0]      rnd_sum;
   logic [ACC_W:0]      rnd_q;
   logic [CODE_W-1:0]   avg_next;
   logic                last_sample;
   logic                handshake;

   // Running totals including the code presented this cycle.
   always_comb begin
      acc_next    = acc_reg + ACC_W'(code);
      min_next    = (code < min_reg) ? code : min_reg;
      max_next    = (code > max_reg) ? code : max_reg;
      rnd_sum     = {1'b0, acc_next} + HALF;
      rnd_q       = rnd_sum >> LOG2_N;
      avg_next    = (|rnd_q[ACC_W:CODE_W]) ? {CODE_W{1'b1}} : rnd_q[CODE_W-1:0];
      last_sample = (cnt_reg == {LOG2_N{1'b1}});
      handshake   = avg_valid_reg & avg_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         min_reg       <= '1;
         max_reg       <= '0;
         avg_data_reg  <= '0;
         min_code_reg  <= '0;
         max_code_reg  <= '0;
         avg_valid_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               acc_reg <= '0;
               cnt_reg <= '0;
               min_reg <= '1;
               max_reg <= '0;
               if (enable) state_reg <= ACCUM;
            end
            ACCUM: begin
               if (!enable) begin
                  state_reg <= IDLE;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  min_reg   <= '1;
                  max_reg   <= '0;
               end else if (sample_en) begin
                  if (last_sample) begin
                     avg_data_reg  <= avg_next;
                     min_code_reg  <= min_next;
                     max_code_reg  <= max_next;
                     avg_valid_reg <= 1'b1;
                     state_reg     <= HOLD;
                     acc_reg       <= '0;
                     cnt_reg       <= '0;
                     min_reg       <= '1;
                     max_reg       <= '0;
                  end else begin
                     acc_reg <= acc_next;
                     cnt_reg <= cnt_reg + LOG2_N'(1);
                     min_reg <= min_next;
                     max_reg <= max_next;
                  end
               end
            end
            HOLD: begin
               if (handshake) begin
                  avg_valid_reg <= 1'b0;
                  // A strobe coinciding with the handshake opens the next window.
                  if (enable && sample_en) begin
                     state_reg <= ACCUM;
                     acc_reg   <= ACC_W'(code);
                     cnt_reg   <= LOG2_N'(1);
                     min_reg   <= code;
                     max_reg   <= code;
                  end else begin
                     state_reg <= enable ? ACCUM : IDLE;
                     acc_reg   <= '0;
                     cnt_reg   <= '0;
                     min_reg   <= '1;
                     max_reg   <= '0;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase

         if (state_reg == HOLD && sample_en && !handshake)
            overrun_reg <= 1'b1;
         else if (clr_overrun)
            overrun_reg <= 1'b0;
      end
   end

   assign avg_data  = avg_data_reg;
   assign min_code  = min_code_reg;
   assign max_code  = max_code_reg;
   assign avg_valid = avg_valid_reg;
   assign overrun   = overrun_reg;

endmodule
